// File: rtl/wr_dest_pkg.sv
// Shared constants for the write-destination pipeline: register numbers and source indices.
// Latency: n/a (constants only).
// Backpressure: n/a.
package wr_dest_pkg;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;
    localparam int REG_SP     = 29;
    localparam int REG_RA     = 31;
    localparam int SRC_RT     = 0;
    localparam int SRC_RD     = 1;
    localparam int SRC_RA     = 2;
    localparam int SRC_SP     = 3;
endpackage

// File: rtl/wr_dest_stage.sv
// One in-flight destination slot: {valid, addr} register with clear/hold/load.
// Latency: 1 cycle from load inputs to outputs.
// Backpressure: hold freezes the slot; clear wins over hold.
module wr_dest_stage #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hold,
    input  logic              clear,
    input  logic              load_vld,
    input  logic [ADDR_W-1:0] load_addr,
    output logic              vld,
    output logic [ADDR_W-1:0] addr
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld  <= 1'b0;
            addr <= '0;
        end else if (clear) begin
            vld  <= 1'b0;
            addr <= '0;
        end else if (!hold) begin
            vld  <= load_vld;
            addr <= load_addr;
        end
    end
endmodule

// File: rtl/wr_dest_pipe.sv
// Write-register destination select plus DEPTH-stage in-flight tracker with RAW hazard query.
// Latency: issue visible on wr_* after 1 edge, on wb_* after DEPTH edges; hazards combinational.
// Backpressure: stall holds every stage; flush clears all. Option: WR_ZERO_SUPPRESS_EN.
module wr_dest_pipe
    import wr_dest_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC),
    parameter int DEPTH   = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      wr_req,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [ADDR_W-1:0]         rs_q,
    input  logic [ADDR_W-1:0]         rt_q,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic                      wr_valid,
    output logic [ADDR_W-1:0]         wb_addr,
    output logic                      wb_valid,
    output logic                      hazard_rs,
    output logic                      hazard_rt,
    output logic                      sel_err
);
    logic              issue;
    logic              sel_ok;
    logic [ADDR_W-1:0] pick;
    logic              pick_live;
    logic              rs_live;
    logic              rt_live;
    logic              in_vld;
    logic [ADDR_W-1:0] in_addr;
    logic              stg_vld  [DEPTH];
    logic [ADDR_W-1:0] stg_addr [DEPTH];

    assign issue  = wr_req && !stall && !flush;
    assign sel_ok = int'(sel) < NUM_SRC;

    // Out-of-range selectors fall back to source 0.
    always_comb begin
        pick = src_addr[ADDR_W-1:0];
        for (int i = 1; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) pick = src_addr[i*ADDR_W +: ADDR_W];
        end
    end

`ifdef WR_ZERO_SUPPRESS_EN
    assign pick_live = (pick != ADDR_W'(REG_ZERO));
    assign rs_live   = (rs_q != ADDR_W'(REG_ZERO));
    assign rt_live   = (rt_q != ADDR_W'(REG_ZERO));
`else
    assign pick_live = 1'b1;
    assign rs_live   = 1'b1;
    assign rt_live   = 1'b1;
`endif

    // Invalid entries always carry address 0 so they can never alias a real register.
    assign in_vld  = issue && pick_live;
    assign in_addr = in_vld ? pick : '0;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic              ld_vld;
        logic [ADDR_W-1:0] ld_addr;
        if (k == 0) begin : g_head
            assign ld_vld  = in_vld;
            assign ld_addr = in_addr;
        end else begin : g_body
            assign ld_vld  = stg_vld[k-1];
            assign ld_addr = stg_addr[k-1];
        end
        wr_dest_stage #(.ADDR_W(ADDR_W)) u_stage (
            .clk       (clk),
            .reset_n   (reset_n),
            .hold      (stall),
            .clear     (flush),
            .load_vld  (ld_vld),
            .load_addr (ld_addr),
            .vld       (stg_vld[k]),
            .addr      (stg_addr[k])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sel_err <= 1'b0;
        else          sel_err <= issue && !sel_ok;
    end

    always_comb begin
        hazard_rs = 1'b0;
        hazard_rt = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (stg_vld[k] && stg_addr[k] == rs_q && rs_live) hazard_rs = 1'b1;
            if (stg_vld[k] && stg_addr[k] == rt_q && rt_live) hazard_rt = 1'b1;
        end
    end

    assign wr_addr  = stg_addr[0];
    assign wr_valid = stg_vld[0];
    assign wb_addr  = stg_addr[DEPTH-1];
    assign wb_valid = stg_vld[DEPTH-1];
endmodule

// File: tb/tb_wr_dest_pipe.sv
// Directed bench for wr_dest_pipe: queue-based reference model checked every cycle plus literal pins.
// Two instances share stimulus: default (4 sources) and a 3-source variant for the range fallback.
module tb_wr_dest_pipe;
    localparam int D = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [19:0] src = '0;
    logic [1:0]  sel = '0;
    logic        wr_req = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [4:0]  rs_q = 5'd7, rt_q = 5'd7;

    logic [4:0] a_wr, a_wb, b_wr, b_wb;
    logic a_wv, a_bv, a_hs, a_ht, a_se;
    logic b_wv, b_bv, b_hs, b_ht, b_se;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wr_dest_pipe #(.ADDR_W(5), .NUM_SRC(4), .DEPTH(D)) dut_a (
        .clk(clk), .reset_n(reset_n), .src_addr(src), .sel(sel), .wr_req(wr_req),
        .stall(stall), .flush(flush), .rs_q(rs_q), .rt_q(rt_q),
        .wr_addr(a_wr), .wr_valid(a_wv), .wb_addr(a_wb), .wb_valid(a_bv),
        .hazard_rs(a_hs), .hazard_rt(a_ht), .sel_err(a_se));

    wr_dest_pipe #(.ADDR_W(5), .NUM_SRC(3), .DEPTH(D)) dut_b (
        .clk(clk), .reset_n(reset_n), .src_addr(src[14:0]), .sel(sel), .wr_req(wr_req),
        .stall(stall), .flush(flush), .rs_q(rs_q), .rt_q(rt_q),
        .wr_addr(b_wr), .wr_valid(b_wv), .wb_addr(b_wb), .wb_valid(b_bv),
        .hazard_rs(b_hs), .hazard_rt(b_ht), .sel_err(b_se));

    typedef struct packed { logic v; logic [4:0] a; } ent_t;
    ent_t m_a[$];
    ent_t m_b[$];
    logic e_a = 1'b0, e_b = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input int nsrc, input logic [19:0] s, input logic [1:0] sl);
        ent_t e;
        int idx;
        idx = (int'(sl) < nsrc) ? int'(sl) : 0;
        e.a = s[idx*5 +: 5];
        e.v = 1'b1;
`ifdef WR_ZERO_SUPPRESS_EN
        if (e.a == 5'd0) e.v = 1'b0;
`endif
        if (!e.v) e.a = 5'd0;
        return e;
    endfunction

    function automatic logic hz(input ent_t q[$], input logic [4:0] r);
        logic h;
        h = 1'b0;
`ifdef WR_ZERO_SUPPRESS_EN
        if (r == 5'd0) return 1'b0;
`endif
        foreach (q[i]) if (q[i].v && q[i].a == r) h = 1'b1;
        return h;
    endfunction

    function automatic void clear_model();
        m_a.delete();
        m_b.delete();
        for (int i = 0; i < D; i++) begin
            m_a.push_back('0);
            m_b.push_back('0);
        end
        e_a = 1'b0;
        e_b = 1'b0;
    endfunction

    // Reference model: index 0 of each queue is the issue stage, index D-1 is write-back.
    initial begin
        clear_model();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n || flush) begin
                clear_model();
            end else if (stall) begin
                e_a = 1'b0;
                e_b = 1'b0;
            end else begin
                m_a.push_front(wr_req ? mk(4, src, sel) : ent_t'('0));
                m_b.push_front(wr_req ? mk(3, src, sel) : ent_t'('0));
                void'(m_a.pop_back());
                void'(m_b.pop_back());
                e_a = wr_req && (int'(sel) >= 4);
                e_b = wr_req && (int'(sel) >= 3);
            end
        end
    end

    always @(negedge clk) begin
        chk("a_wr_addr",  32'(a_wr), 32'(m_a[0].a));
        chk("a_wr_valid", 32'(a_wv), 32'(m_a[0].v));
        chk("a_wb_addr",  32'(a_wb), 32'(m_a[D-1].a));
        chk("a_wb_valid", 32'(a_bv), 32'(m_a[D-1].v));
        chk("a_haz_rs",   32'(a_hs), 32'(hz(m_a, rs_q)));
        chk("a_haz_rt",   32'(a_ht), 32'(hz(m_a, rt_q)));
        chk("a_sel_err",  32'(a_se), 32'(e_a));
        chk("b_wr_addr",  32'(b_wr), 32'(m_b[0].a));
        chk("b_wr_valid", 32'(b_wv), 32'(m_b[0].v));
        chk("b_wb_addr",  32'(b_wb), 32'(m_b[D-1].a));
        chk("b_wb_valid", 32'(b_bv), 32'(m_b[D-1].v));
        chk("b_haz_rs",   32'(b_hs), 32'(hz(m_b, rs_q)));
        chk("b_haz_rt",   32'(b_ht), 32'(hz(m_b, rt_q)));
        chk("b_sel_err",  32'(b_se), 32'(e_b));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        chk("rst_wr_valid", 32'(a_wv), 0);
        chk("rst_wb_valid", 32'(a_bv), 0);
        chk("rst_sel_err",  32'(a_se), 0);
        reset_n = 1'b1;
        src = {5'd29, 5'd31, 5'd21, 5'd9};
        step();

        // Sources 0..3 back to back.
        wr_req = 1'b1;
        sel = 2'd0; step(); chk("seq_wr0", 32'(a_wr), 9);
        sel = 2'd1; step(); chk("seq_wr1", 32'(a_wr), 21);
        sel = 2'd2; step(); chk("seq_wr2", 32'(a_wr), 31); chk("seq_wb0", 32'(a_wb), 9);
        chk("seq_wbv0", 32'(a_bv), 1);
        sel = 2'd3; step(); chk("seq_wr3", 32'(a_wr), 29); chk("seq_wb1", 32'(a_wb), 21);
        chk("seq_selerr", 32'(a_se), 0);
        wr_req = 1'b0;
        step(); chk("seq_wb2", 32'(a_wb), 31); chk("seq_wv_idle", 32'(a_wv), 0);
        step(); chk("seq_wb3", 32'(a_wb), 29);
        step(); chk("seq_wb_done", 32'(a_bv), 0);

        // Hazard on rd=21 lasts exactly three cycles.
        rs_q = 5'd21;
        wr_req = 1'b1; sel = 2'd1; step(); chk("hz_c1", 32'(a_hs), 1);
        wr_req = 1'b0; step(); chk("hz_c2", 32'(a_hs), 1);
        step(); chk("hz_c3", 32'(a_hs), 1);
        step(); chk("hz_c4", 32'(a_hs), 0);
        rs_q = 5'd7;

        // Stall two cycles with one entry in flight; wr_req during stall is ignored.
        wr_req = 1'b1; sel = 2'd0; step();
        stall = 1'b1; sel = 2'd3; step(); chk("st_hold_wr", 32'(a_wr), 9); chk("st_b_selerr", 32'(b_se), 0);
        step(); chk("st_hold_wv", 32'(a_wv), 1);
        stall = 1'b0; wr_req = 1'b0; sel = 2'd0;
        step(); chk("st_n3_wbv", 32'(a_bv), 0); chk("st_n3_wv", 32'(a_wv), 0);
        step(); chk("st_n4_wbv", 32'(a_bv), 1); chk("st_n4_wb", 32'(a_wb), 9);
        step(); chk("st_n5_wbv", 32'(a_bv), 0);

        // Flush overrides stall and wr_req.
        wr_req = 1'b1;
        sel = 2'd0; step();
        sel = 2'd1; step();
        sel = 2'd2; step();
        rs_q = 5'd9; rt_q = 5'd21;
        flush = 1'b1; stall = 1'b1; step();
        chk("fl_wv", 32'(a_wv), 0); chk("fl_wbv", 32'(a_bv), 0);
        chk("fl_hrs", 32'(a_hs), 0); chk("fl_hrt", 32'(a_ht), 0);
        flush = 1'b0; stall = 1'b0; wr_req = 1'b0;
        step(); chk("fl_wbv2", 32'(a_bv), 0);
        step(); chk("fl_wbv3", 32'(a_bv), 0);
        rs_q = 5'd7; rt_q = 5'd7;

        // Out-of-range selector on the 3-source instance.
        wr_req = 1'b1; sel = 2'd3; step();
        chk("se_b_wr", 32'(b_wr), 9); chk("se_b_err", 32'(b_se), 1);
        chk("se_a_wr", 32'(a_wr), 29); chk("se_a_err", 32'(a_se), 0);
        wr_req = 1'b0; step(); chk("se_b_err_off", 32'(b_se), 0);

        // Asynchronous reset mid-flight.
        wr_req = 1'b1; sel = 2'd1; step();
        sel = 2'd2; step();
        wr_req = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("ar_a_wv", 32'(a_wv), 0); chk("ar_a_wr", 32'(a_wr), 0);
        chk("ar_a_wbv", 32'(a_bv), 0); chk("ar_a_wb", 32'(a_wb), 0);
        chk("ar_b_wv", 32'(b_wv), 0); chk("ar_b_se", 32'(b_se), 0);
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ar_no_wb", 32'(a_bv), 0);
        end

        // Destination $zero.
        src = {5'd29, 5'd31, 5'd21, 5'd0};
        rs_q = 5'd0;
        wr_req = 1'b1; sel = 2'd0; step();
`ifdef WR_ZERO_SUPPRESS_EN
        chk("z_wv", 32'(a_wv), 0); chk("z_hrs", 32'(a_hs), 0);
`else
        chk("z_wv", 32'(a_wv), 1); chk("z_hrs", 32'(a_hs), 1);
`endif
        wr_req = 1'b0;
        step(); step(); step();
        rs_q = 5'd7;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
